// File: rtl/core_pkg.sv
// Shared types and constants for the fetch-stage instruction store.
package core_pkg;
    parameter int HW_WIDTH_DEF = 16;

    // Low two bits of the first halfword that mark a 32-bit instruction.
    localparam logic [1:0] LEN32_CODE = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;
endpackage

// File: rtl/imem_array.sv
// Halfword array: one write port, two combinational read ports (idx, idx+1 mod DEPTH).
module imem_array #(
    parameter  int HW_WIDTH = 16,
    parameter  int DEPTH    = 32,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [HW_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [HW_WIDTH-1:0] rdata_lo_o,
    output logic [HW_WIDTH-1:0] rdata_hi_o
);
    logic [HW_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]       raddr_hi;

    // No reset on the storage so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // DEPTH is a power of two, so the AW-bit increment wraps to entry 0.
    assign raddr_hi   = raddr_i + AW'(1);
    assign rdata_lo_o = mem_q[raddr_i];
    assign rdata_hi_o = mem_q[raddr_hi];
endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction store with zero-fill after reset/clear, program-load port and
// a registered, back-pressurable fetch port returning 32-bit windows.
module instr_fetch_mem
    import core_pkg::*;
#(
    parameter  int HW_WIDTH = HW_WIDTH_DEF,
    parameter  int DEPTH    = 32,
    parameter  int PC_WIDTH = 32,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  load_valid,
    input  logic [AW-1:0]         load_addr,
    input  logic [HW_WIDTH-1:0]   load_data,
    output logic                  load_ready,
    input  logic                  fetch_req,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [2*HW_WIDTH-1:0] fetch_instr,
    output logic                  fetch_len32,
    output logic                  fetch_fault,
    input  logic                  fetch_accept
);
    state_e                state_q, state_d;
    logic [AW-1:0]         clear_ptr_q, clear_ptr_d;
    logic                  valid_q, valid_d;
    logic [2*HW_WIDTH-1:0] instr_q, instr_d;
    logic                  len32_q, len32_d;
    logic                  fault_q, fault_d;

    logic                  in_clear, run_ok, load_go, fetch_go, pc_oob;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [HW_WIDTH-1:0]   mem_wdata, rd_lo, rd_hi;

    assign in_clear = (state_q == CLEAR);
    // clear_req outranks load and fetch, so neither is offered that cycle.
    assign run_ok      = !in_clear && !clear_req;
    assign load_ready  = run_ok;
    assign fetch_ready = run_ok && !load_valid && (!valid_q || fetch_accept);
    assign load_go     = load_valid && load_ready;
    assign fetch_go    = fetch_req && fetch_ready;
    assign pc_oob      = |fetch_pc[PC_WIDTH-1:AW];

    assign mem_we    = in_clear || load_go;
    assign mem_waddr = in_clear ? clear_ptr_q : load_addr;
    assign mem_wdata = in_clear ? '0 : load_data;

    imem_array #(
        .HW_WIDTH (HW_WIDTH),
        .DEPTH    (DEPTH)
    ) u_array (
        .clk        (clk),
        .we_i       (mem_we),
        .waddr_i    (mem_waddr),
        .wdata_i    (mem_wdata),
        .raddr_i    (fetch_pc[AW-1:0]),
        .rdata_lo_o (rd_lo),
        .rdata_hi_o (rd_hi)
    );

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        len32_d     = len32_q;
        fault_d     = fault_q;
        if (clear_req) begin
            state_d     = CLEAR;
            clear_ptr_d = '0;
            valid_d     = 1'b0;
        end else if (in_clear) begin
            clear_ptr_d = clear_ptr_q + AW'(1);
            if (clear_ptr_q == AW'(DEPTH - 1)) state_d = RUN;
        end else if (fetch_go) begin
            valid_d = 1'b1;
            fault_d = pc_oob;
            instr_d = pc_oob ? '0 : {rd_hi, rd_lo};
            len32_d = !pc_oob && (rd_lo[1:0] == LEN32_CODE);
        end else if (fetch_accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            len32_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            len32_q     <= len32_d;
            fault_q     <= fault_d;
        end
    end

    assign busy        = in_clear;
    assign fetch_valid = valid_q;
    assign fetch_instr = instr_q;
    assign fetch_len32 = len32_q;
    assign fetch_fault = fault_q;
endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem (DEPTH=32, 16-bit halfwords).
module tb_instr_fetch_mem;
    localparam int HW = 16;
    localparam int DEPTH = 32;
    localparam int PCW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear_req = 1'b0;
    logic            busy;
    logic            load_valid = 1'b0;
    logic [AW-1:0]   load_addr = '0;
    logic [HW-1:0]   load_data = '0;
    logic            load_ready;
    logic            fetch_req = 1'b0;
    logic [PCW-1:0]  fetch_pc = '0;
    logic            fetch_ready;
    logic            fetch_valid;
    logic [2*HW-1:0] fetch_instr;
    logic            fetch_len32;
    logic            fetch_fault;
    logic            fetch_accept = 1'b1;

    int passed = 0;
    int total  = 0;

    instr_fetch_mem #(.HW_WIDTH(HW), .DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_req    (clear_req),
        .busy         (busy),
        .load_valid   (load_valid),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .fetch_req    (fetch_req),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .fetch_len32  (fetch_len32),
        .fetch_fault  (fetch_fault),
        .fetch_accept (fetch_accept)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a falling edge; drives one load through the next rising edge.
    task automatic do_load(input logic [AW-1:0] a, input logic [HW-1:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic do_fetch(input string tag, input logic [PCW-1:0] pc,
                            input logic [31:0] e_instr, input logic e_len, input logic e_fault);
        fetch_req    = 1'b1;
        fetch_pc     = pc;
        fetch_accept = 1'b1;
        #1;
        chk({tag, "_ready"}, fetch_ready, 1'b1);
        @(negedge clk);
        fetch_req = 1'b0;
        chk({tag, "_valid"}, fetch_valid, 1'b1);
        chk({tag, "_instr"}, fetch_instr, e_instr);
        chk({tag, "_len32"}, fetch_len32, e_len);
        chk({tag, "_fault"}, fetch_fault, e_fault);
    endtask

    // Sampled from the first falling edge of the fill; counts busy cycles.
    task automatic wait_fill(input string tag);
        int   n = 0;
        logic rdy_seen = 1'b0;
        while (busy && n < 100) begin
            n++;
            if (fetch_ready || load_ready) rdy_seen = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, n, 32);
        chk({tag, "_no_ready_in_fill"}, rdy_seen, 1'b0);
    endtask

    logic [31:0] stream_exp [8];

    initial begin
        // 1. reset state and post-reset fill
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b1);
        chk("rst_valid", fetch_valid, 1'b0);
        chk("rst_instr", fetch_instr, 32'h0);
        chk("rst_len_fault", {fetch_len32, fetch_fault}, 2'b00);
        chk("rst_readies", {load_ready, fetch_ready}, 2'b00);
        rst_n = 1'b1;
        wait_fill("reset_fill");
        do_fetch("t1_pc5", 5, 32'h0000_0000, 1'b0, 1'b0);

        // 2. length decode
        do_load(3, 16'h1233);
        do_load(4, 16'hABCD);
        do_fetch("t2_pc3", 3, 32'hABCD_1233, 1'b1, 1'b0);
        do_fetch("t2_pc4", 4, 32'h0000_ABCD, 1'b0, 1'b0);

        // 3. wrap and out-of-range
        do_load(31, 16'h0013);
        do_load(0, 16'h5A5A);
        do_fetch("t3_pc31", 31, 32'h5A5A_0013, 1'b1, 1'b0);
        do_fetch("t3_pc32", 32, 32'h0, 1'b0, 1'b1);
        do_fetch("t3_pchi", 32'h8000_0003, 32'h0, 1'b0, 1'b1);

        // 4. backpressure then streaming
        do_load(1, 16'h1111);
        do_load(2, 16'h2222);
        @(negedge clk);
        chk("t4_drained", fetch_valid, 1'b0);
        fetch_req = 1'b1; fetch_pc = 1; fetch_accept = 1'b0;
        @(negedge clk);
        fetch_pc = 2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_hold_ready", fetch_ready, 1'b0);
            @(negedge clk);
            chk("t4_hold_valid", fetch_valid, 1'b1);
            chk("t4_hold_instr", fetch_instr, 32'h2222_1111);
        end
        fetch_accept = 1'b1;
        #1;
        chk("t4_accept_ready", fetch_ready, 1'b1);
        @(negedge clk);
        chk("t4_b2b_valid", fetch_valid, 1'b1);
        chk("t4_b2b_instr", fetch_instr, 32'h1233_2222);

        stream_exp = '{32'h1111_5A5A, 32'h2222_1111, 32'h1233_2222, 32'hABCD_1233,
                       32'h0000_ABCD, 32'h0, 32'h0, 32'h0};
        fetch_pc = 0;
        #1;
        chk("t4_stream_ready0", fetch_ready, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("t4_stream_valid", fetch_valid, 1'b1);
            chk("t4_stream_instr", fetch_instr, stream_exp[i-1]);
            if (i < 8) fetch_pc = i;
            else fetch_req = 1'b0;
        end
        @(negedge clk);
        chk("t4_stream_end", fetch_valid, 1'b0);

        // 5. load/fetch collision
        load_valid = 1'b1; load_addr = 6; load_data = 16'h6B6B;
        fetch_req = 1'b1; fetch_pc = 6;
        #1;
        chk("t5_collide_fready", fetch_ready, 1'b0);
        chk("t5_collide_lready", load_ready, 1'b1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("t5_no_resp", fetch_valid, 1'b0);
        do_fetch("t5_rdnew", 6, 32'h0000_6B6B, 1'b1, 1'b0);

        // 6. clear while holding a response
        fetch_req = 1'b1; fetch_pc = 3; fetch_accept = 1'b0;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        chk("t6_holding", fetch_valid, 1'b1);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        fetch_accept = 1'b1;
        chk("t6_dropped", fetch_valid, 1'b0);
        wait_fill("clear_fill");
        do_fetch("t6_pc3_zero", 3, 32'h0, 1'b0, 1'b0);
        do_fetch("t6_pc31_zero", 31, 32'h0, 1'b0, 1'b0);

        // reset in the middle of a fill restarts it from entry 0
        do_load(9, 16'h0F0F);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_midrst_busy", busy, 1'b1);
        rst_n = 1'b1;
        wait_fill("midreset_fill");
        do_fetch("t6_pc9_zero", 9, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
- Parametrised instruction store for the core's fetch stage; successor to the fixed 32-entry combinational halfword ROM.
- Halfword-addressed array with a registered fetch port and a valid/accept handshake.
- Assembles 32-bit fetch windows from two consecutive halfwords and flags 16/32-bit instruction length.
- Adds a program-load write port, a post-reset hardware zero-fill, and an out-of-range fault.

Parameters:
- HW_WIDTH, 16, halfword width in bits; fetch window is 2*HW_WIDTH.
- DEPTH, 32, number of halfword entries; power of two, >= 4.
- PC_WIDTH, 32, width of fetch_pc.
- AW, $clog2(DEPTH), derived (localparam); array index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear_req  in  1  pulse: restart zero-fill of the whole array
- busy  out  1  high while zero-fill is in progress
- load_valid  in  1  program-load write request
- load_addr  in  AW  halfword index to write
- load_data  in  HW_WIDTH  halfword to write
- load_ready  out  1  write accepted this cycle when load_valid && load_ready
- fetch_req  in  1  fetch request
- fetch_pc  in  PC_WIDTH  halfword index of the instruction
- fetch_ready  out  1  fetch accepted when fetch_req && fetch_ready
- fetch_valid  out  1  response held in the output register
- fetch_instr  out  2*HW_WIDTH  {mem[pc+1], mem[pc]}
- fetch_len32  out  1  1 = 32-bit instruction (mem[pc][1:0]==2'b11), 0 = 16-bit
- fetch_fault  out  1  fetch_pc >= DEPTH
- fetch_accept  in  1  consumer takes the response

Behaviour:
- Reset (async, rst_n low): state=CLEAR, clear_ptr=0, fetch_valid=0, fetch_instr=0, fetch_len32=0, fetch_fault=0, busy=1, load_ready=0, fetch_ready=0. The array itself is not reset.
- CLEAR:
  - Writes 0 to mem[clear_ptr] each cycle and increments clear_ptr.
  - After writing entry DEPTH-1, moves to RUN. Fill takes exactly DEPTH cycles; busy=1 throughout.
  - load and fetch are not accepted.
  - A clear_req during CLEAR restarts the fill at 0.
  - A clear_req in RUN enters CLEAR next cycle; any held response is dropped (fetch_valid=0).
- RUN:
  - busy=0, load_ready=1.
  - fetch_ready = !load_valid && (!fetch_valid || fetch_accept).
  - Load priority: when load_valid, the write happens this cycle and no fetch is accepted.
- Fetch (accepted in cycle N): output register loads in N+1, so fetch_valid=1 at N+1 (one-cycle latency).
  - idx = fetch_pc[AW-1:0].
  - fetch_instr = {mem[(idx+1) mod DEPTH], mem[idx]}; the upper halfword wraps to entry 0 when idx=DEPTH-1.
  - fetch_len32 = mem[idx][1:0]==2'b11.
  - If fetch_pc >= DEPTH (any upper bit set): fetch_fault=1, fetch_instr=0, fetch_len32=0.
- Response hold: outputs are stable while fetch_valid && !fetch_accept.
  - Accept with no new fetch: fetch_valid drops next cycle.
  - Accept together with an accepted new fetch: back-to-back, fetch_valid stays 1 and the data updates. This gives full throughput of 1 fetch/cycle.
- Read/write ordering: a fetch accepted in the cycle after a load to the same index returns the new data (write-then-read, no bypass needed). A same-cycle load and fetch cannot both be accepted.
- clear_req has priority over load and fetch in the same cycle.
- No combinational path from fetch_pc to fetch_instr.

Decomposition:
- Shared package (core_pkg):
  - HW_WIDTH default.
  - Length-decode constant LEN32_CODE = 2'b11.
  - State enum {CLEAR, RUN}.
- One natural sub-module: imem_array.
  - Single write port (muxed between clear and load) and two combinational read ports (idx, idx+1 mod DEPTH).
  - Lets the array map to distributed RAM.
- The handshake/FSM stays in instr_fetch_mem.

Test Plan:
1. Reset then idle: busy=1 for exactly 32 cycles and fetch_ready=0 during that time. Then fetch pc=5 -> next cycle fetch_valid=1, fetch_instr=0x00000000, fetch_len32=0, fetch_fault=0.
2. Load mem[3]=0x1233 and mem[4]=0xABCD, then fetch pc=3 -> fetch_instr=0xABCD1233, fetch_len32=1. Then fetch pc=4 with mem[4][1:0]=01 -> fetch_len32=0.
3. Wrap: load mem[31]=0x0013 and mem[0]=0x5A5A, fetch pc=31 -> fetch_instr=0x5A5A0013. Fetch pc=32 -> fetch_fault=1, fetch_instr=0.
4. Backpressure: fetch pc=1 with fetch_accept=0 for 3 cycles and fetch_req held with pc=2 -> fetch_ready=0 and outputs frozen. The cycle fetch_accept=1, pc=2 is accepted and its data appears next cycle. Streaming pc=0..7 with accept=1 gives 8 responses in 8 consecutive cycles.
5. Load/fetch collision: load_valid with addr 6 and fetch_req pc=6 in the same cycle -> fetch_ready=0. The next cycle's fetch returns the new mem[6].
6. clear_req while fetch_valid=1 and holding -> fetch_valid=0 next cycle, busy=1 for 32 cycles, previously loaded data reads back 0. Deasserting rst_n mid-fill restarts it: busy lasts a full 32 cycles after release.
